// File: rtl/ysyx_24100012_mem_arbiter.sv
// ysyx_24100012_mem_arbiter: shares one memory port between the IFU and the LSU.
// One transaction is in flight at a time: IDLE (arbitrate) -> REQ (present to
// memory) -> WAIT (await response, guarded by a watchdog) -> IDLE.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin on contention instead of
// fixed LSU priority.
module ysyx_24100012_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,
    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    rsp_err,
    output logic                    busy
);
    localparam int MW = DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                state_q;
    logic                  owner_lsu_q;   // 0 = IFU, 1 = LSU
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MW-1:0]         wmask_q;
    logic [CW-1:0]         cnt_q;
    logic                  ifu_rsp_valid_q, lsu_rsp_valid_q, rsp_err_q;
    logic [DATA_WIDTH-1:0] ifu_rdata_q, lsu_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic                  rr_lsu_q;      // 1 = LSU wins the next contention
`endif

    logic                  gnt_ifu, gnt_lsu;
    logic                  rsp_fire, tmo_fire;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Grant decode: only in IDLE and never while reset is held.
    always_comb begin
        gnt_ifu = 1'b0;
        gnt_lsu = 1'b0;
        if (state_q == S_IDLE && !rst) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (ifu_req_valid && lsu_req_valid) begin
                gnt_lsu = rr_lsu_q;
                gnt_ifu = !rr_lsu_q;
            end else begin
                gnt_lsu = lsu_req_valid;
                gnt_ifu = ifu_req_valid;
            end
`else
            gnt_lsu = lsu_req_valid;
            gnt_ifu = ifu_req_valid && !lsu_req_valid;
`endif
        end
    end

    // Completion decode: a real response beats the watchdog in the same cycle.
    always_comb begin
        rsp_fire = ((state_q == S_REQ) && mem_req_ready && mem_rsp_valid) ||
                   ((state_q == S_WAIT) && mem_rsp_valid);
        tmo_fire = (state_q == S_WAIT) && !mem_rsp_valid &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        rdata_d  = '0;
        if (rsp_fire && !(owner_lsu_q && wen_q))
            rdata_d = mem_rdata;
    end

    // Main FSM with registered request fields and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            owner_lsu_q     <= 1'b0;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            cnt_q           <= '0;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            rsp_err_q       <= 1'b0;
            ifu_rdata_q     <= '0;
            lsu_rdata_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_lsu_q        <= 1'b1;
`endif
        end else begin
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            rsp_err_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_ifu || gnt_lsu) begin
                        owner_lsu_q <= gnt_lsu;
                        addr_q      <= gnt_lsu ? lsu_addr : ifu_addr;
                        wen_q       <= gnt_lsu && lsu_wen;
                        wdata_q     <= gnt_lsu ? lsu_wdata : '0;
                        wmask_q     <= gnt_lsu ? lsu_wmask : '0;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_lsu_q    <= gnt_ifu;
`endif
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        cnt_q   <= '0;
                        state_q <= mem_rsp_valid ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_fire || tmo_fire)
                        state_q <= S_IDLE;
                    else
                        cnt_q <= cnt_q + CW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
            if (rsp_fire || tmo_fire) begin
                rsp_err_q <= tmo_fire;
                if (owner_lsu_q) begin
                    lsu_rsp_valid_q <= 1'b1;
                    lsu_rdata_q     <= rdata_d;
                end else begin
                    ifu_rsp_valid_q <= 1'b1;
                    ifu_rdata_q     <= rdata_d;
                end
            end
        end
    end

    assign ifu_req_ready = gnt_ifu;
    assign lsu_req_ready = gnt_lsu;
    assign ifu_rsp_valid = ifu_rsp_valid_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign ifu_rdata     = ifu_rdata_q;
    assign lsu_rdata     = lsu_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign busy          = (state_q != S_IDLE);

endmodule
